alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Micro-sequencer that drives the team's 8-bit combinational ALU (src1, src2, en, 3-bit Op in; dst, zero out).
- Holds a small register file and accepts one instruction per valid/ready handshake.
- For each instruction it reads operands, issues them to the ALU for one cycle, and writes the result back.
- Also exposes a sticky zero flag, a done pulse and a debug read port.

Parameters:
- DW, 8, datapath width; must match the ALU width.
- RAW, 2, register-address width; register file has NREG = 2**RAW entries (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- cmd_valid  input  1  instruction present.
- cmd_ready  output  1  sequencer can accept an instruction.
- cmd_ld  input  1  1 = load immediate; 0 = ALU operation.
- cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 shl1, 011 pass, 100 and, 101 or, 110 xor, 111 not).
- cmd_rd  input  RAW  destination register.
- cmd_rs1  input  RAW  source register 1.
- cmd_rs2  input  RAW  source register 2.
- cmd_imm  input  DW  immediate for loads.
- alu_en  output  1  ALU enable.
- alu_op  output  3  ALU opcode.
- alu_src1  output  DW  ALU operand 1.
- alu_src2  output  DW  ALU operand 2.
- alu_dst  input  DW  ALU result.
- alu_zero  input  1  ALU zero flag.
- done  output  1  one-cycle pulse when a write-back occurs.
- zero_flag  output  1  zero result of the last completed ALU instruction.
- dbg_addr  input  RAW  debug read address.
- dbg_data  output  DW  combinational read: R[dbg_addr].

Behaviour:
- State machine has three states: IDLE, ISSUE, WB.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All R[i] = 0, zero_flag = 0, done = 0.
  - Latched instruction fields = 0, result latch = 0.
  - cmd_ready = 1 once reset is released.
- Reset asserted mid-instruction aborts it: no write-back and no done pulse.
- cmd_ready = 1 only in IDLE (Moore output, no combinational path from cmd_valid).
- Accept occurs on a clock edge with cmd_valid & cmd_ready; the edge latches all cmd_* fields.
  - cmd_ld = 1: IDLE -> WB; the result latch takes cmd_imm.
  - cmd_ld = 0: IDLE -> ISSUE.
- ISSUE (exactly one cycle):
  - alu_en = 1, alu_op = latched op.
  - alu_src1 = R[rs1], alu_src2 = R[rs2].
  - At the ending edge, latch alu_dst and alu_zero; go to WB.
- Outside ISSUE: alu_en = 0, alu_op = 0, alu_src1 = 0, alu_src2 = 0 (registered outputs or decoded from state; glitch-free).
- WB (one cycle):
  - done = 1.
  - At the ending edge, R[rd] <= result latch; go to IDLE.
  - zero_flag <= latched alu_zero for ALU instructions only; loads leave zero_flag unchanged.
- Latency, with acceptance at edge N:
  - ALU instruction: done is high in cycle N+2; the register is visible on dbg_data from cycle N+3.
  - Load: done is high in cycle N+1; the register is visible from N+2.
- Throughput:
  - Back-to-back ALU instructions: one accept every 3 cycles.
  - Back-to-back loads: one accept every 2 cycles.
- Hazards: none.
  - Source registers are read in ISSUE, after any prior write-back has completed.
  - rd == rs1 == rs2 is legal: old values are used, new value is written.
- Arithmetic wraps modulo 2^DW and is computed by the ALU; the sequencer adds no carry or overflow state.
- Opcodes 010, 011 and 111 ignore src2, but the sequencer still drives R[rs2].
- cmd_* changes while cmd_ready = 0 are ignored.
- If cmd_valid drops without an accept, nothing happens.

Optional Feature:
- Macro: ALU_SEQ_CNT_EN.
- When defined:
  - Adds output instr_cnt [15:0], counting completed write-backs (incremented in WB).
  - Reset value is 0; wraps 0xFFFF -> 0x0000.
  - A reset mid-instruction leaves the count unincremented.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then load R0 = 0x05 and R1 = 0x03 -> done one cycle after each accept; dbg_data(0) = 0x05, dbg_data(1) = 0x03; zero_flag stays 0.
- ADD rd=2, rs1=0, rs2=1 -> in the ISSUE cycle alu_en = 1, op = 000, src1 = 0x05, src2 = 0x03; done at N+2; R2 = 0x08; zero_flag = 0.
- SUB rd=3, rs1=0, rs2=0 -> R3 = 0x00, zero_flag = 1; then load R3 = 0x00 -> zero_flag stays 1.
- Load R0 = 0x80, then SHL rd=0, rs1=0 -> R0 = 0x00 (wrap-around), zero_flag = 1; then NOT rd=1, rs1=0 -> R1 = 0xFF, zero_flag = 0.
- Hold cmd_valid high with 4 ALU instructions queued -> accepts spaced 3 cycles apart; cmd_ready low during ISSUE/WB; alu_en never high outside ISSUE.
- Assert rst_n low during the ISSUE of ADD rd=2 -> no done pulse; all registers read 0; cmd_ready = 1 after release; instr_cnt = 0 when ALU_SEQ_CNT_EN is defined.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Bus bundle between the ALU micro-sequencer and its environment.
// It carries the instruction handshake and the connection to the ALU.
//
//   Instruction side: cmd_valid, cmd_ready, cmd_ld, cmd_op, cmd_rd, cmd_rs1,
//                     cmd_rs2, cmd_imm
//   ALU side:         alu_en, alu_op, alu_src1, alu_src2 (sequencer -> ALU)
//                     alu_dst, alu_zero                  (ALU -> sequencer)
//
// Modports:
//   slave  - the sequencer: takes instructions and drives the ALU.
//   master - the environment: issues instructions and hosts the ALU.
// ----------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
    parameter int DW  = 8,
    parameter int RAW = 2
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_ld;
    logic [2:0]     cmd_op;
    logic [RAW-1:0] cmd_rd;
    logic [RAW-1:0] cmd_rs1;
    logic [RAW-1:0] cmd_rs2;
    logic [DW-1:0]  cmd_imm;

    logic           alu_en;
    logic [2:0]     alu_op;
    logic [DW-1:0]  alu_src1;
    logic [DW-1:0]  alu_src2;
    logic [DW-1:0]  alu_dst;
    logic           alu_zero;

    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output alu_en, alu_op, alu_src1, alu_src2,
        input  alu_dst, alu_zero
    );

    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  alu_en, alu_op, alu_src1, alu_src2,
        output alu_dst, alu_zero
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl
// Micro-sequencer for the 8-bit combinational ALU. It holds a small register
// file and accepts one instruction per valid/ready handshake.
//   Load:  IDLE -> WB             (R[rd] <= imm)
//   ALU op: IDLE -> ISSUE -> WB   (R[rd] <= ALU(R[rs1], R[rs2]))
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   bus        alu_seq_ctrl_if.slave (instruction handshake + ALU connection)
//   done       one-cycle pulse during the write-back cycle
//   zero_flag  zero result of the last completed ALU instruction (loads
//              leave it untouched)
//   dbg_addr   debug read address
//   dbg_data   combinational read of R[dbg_addr]
//   instr_cnt  16-bit count of completed write-backs, wraps (only present
//              when ALU_SEQ_CNT_EN is defined)
//
// Build option: define ALU_SEQ_CNT_EN to add the instr_cnt output.
// ----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int DW  = 8,
    parameter int RAW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_seq_ctrl_if.slave   bus,
    output logic            done,
    output logic            zero_flag,
    input  logic [RAW-1:0]  dbg_addr,
    output logic [DW-1:0]   dbg_data
`ifdef ALU_SEQ_CNT_EN
    ,
    output logic [15:0]     instr_cnt
`endif
);
    localparam int NREG = 2**RAW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WB    = 2'd2;

    logic [1:0]     state_reg;
    logic           ld_reg;
    logic [2:0]     op_reg;
    logic [RAW-1:0] rd_reg;
    logic [RAW-1:0] rs1_reg;
    logic [RAW-1:0] rs2_reg;
    logic [DW-1:0]  result_reg;
    logic           alu_zero_reg;
    logic           zero_flag_reg;

    logic [DW-1:0]  regs_reg [NREG];
    logic [NREG-1:0] wr_en;

    logic accept;
    logic in_issue;
    logic in_wb;

    // cmd_ready comes from state alone, so accept does not feed back into it.
    assign accept   = (state_reg == IDLE) && bus.cmd_valid;
    assign in_issue = (state_reg == ISSUE);
    assign in_wb    = (state_reg == WB);

    // ------------------------------------------------------------------
    // Control FSM and instruction / result latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ld_reg       <= 1'b0;
            op_reg       <= '0;
            rd_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            result_reg   <= '0;
            alu_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        ld_reg  <= bus.cmd_ld;
                        op_reg  <= bus.cmd_op;
                        rd_reg  <= bus.cmd_rd;
                        rs1_reg <= bus.cmd_rs1;
                        rs2_reg <= bus.cmd_rs2;
                        if (bus.cmd_ld) begin
                            // A load skips the ALU; the immediate is the result.
                            result_reg <= bus.cmd_imm;
                            state_reg  <= WB;
                        end else begin
                            state_reg  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    result_reg   <= bus.alu_dst;
                    alu_zero_reg <= bus.alu_zero;
                    state_reg    <= WB;
                end
                WB: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Sticky zero flag: only ALU instructions update it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag_reg <= 1'b0;
        end else if (in_wb && !ld_reg) begin
            zero_flag_reg <= alu_zero_reg;
        end
    end

    // ------------------------------------------------------------------
    // Register file: one write enable per entry, decoded from rd in WB
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_en
            assign wr_en[gi] = in_wb && (rd_reg == RAW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= result_reg;
                end
            end
        end
    end

`ifdef ALU_SEQ_CNT_EN
    logic [15:0] instr_cnt_reg;

    // Counts completed write-backs; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_reg <= '0;
        end else if (in_wb) begin
            instr_cnt_reg <= instr_cnt_reg + 16'd1;
        end
    end

    assign instr_cnt = instr_cnt_reg;
`endif

    // ------------------------------------------------------------------
    // Outputs. The ALU drive is gated by the registered state, so the ALU
    // sees zeros outside ISSUE. Operands are read in ISSUE, after any
    // earlier write-back has landed, so there are no hazards to resolve.
    // ------------------------------------------------------------------
    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.alu_en    = in_issue;
    assign bus.alu_op    = in_issue ? op_reg            : 3'd0;
    assign bus.alu_src1  = in_issue ? regs_reg[rs1_reg] : '0;
    assign bus.alu_src2  = in_issue ? regs_reg[rs2_reg] : '0;

    assign done      = in_wb;
    assign zero_flag = zero_flag_reg;
    assign dbg_data  = regs_reg[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. It hosts a behavioural model of the 8-bit
// ALU on the interface. Expected register contents and flags are constants
// worked out by hand. Inputs change and outputs are sampled on the falling
// edge.
// Define ALU_SEQ_CNT_EN to build and check the instruction counter as well.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic       done;
    logic       zero_flag;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef ALU_SEQ_CNT_EN
    logic [15:0] instr_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    alu_seq_ctrl_if #(.DW(8), .RAW(2)) bus ();

    alu_seq_ctrl #(.DW(8), .RAW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .done      (done),
        .zero_flag (zero_flag),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
`ifdef ALU_SEQ_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the team's combinational ALU.
    logic [7:0] alu_res;
    always_comb begin
        alu_res = 8'h00;
        case (bus.alu_op)
            3'b000: alu_res = bus.alu_src1 + bus.alu_src2;
            3'b001: alu_res = bus.alu_src1 - bus.alu_src2;
            3'b010: alu_res = {bus.alu_src1[6:0], 1'b0};
            3'b011: alu_res = bus.alu_src1;
            3'b100: alu_res = bus.alu_src1 & bus.alu_src2;
            3'b101: alu_res = bus.alu_src1 | bus.alu_src2;
            3'b110: alu_res = bus.alu_src1 ^ bus.alu_src2;
            default: alu_res = ~bus.alu_src1;
        endcase
    end
    assign bus.alu_dst  = alu_res;
    assign bus.alu_zero = (alu_res == 8'h00);

    // Stimulus driver only; it makes no checks.
    task automatic drive(input logic v, input logic ld, input logic [2:0] op,
                         input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        bus.cmd_valid = v;
        bus.cmd_ld    = ld;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        dbg_addr = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
        nvec++; if (zero_flag !== 1'b0) begin nerr++; $display("FAIL rst_zf: got %b want 0", zero_flag); end
        nvec++; if (bus.alu_en !== 1'b0) begin nerr++; $display("FAIL rst_alu_en: got %b want 0", bus.alu_en); end
        nvec++; if (bus.alu_src1 !== 8'h00) begin nerr++; $display("FAIL rst_src1: got %h want 00", bus.alu_src1); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            nvec++; if (dbg_data !== 8'h00) begin nerr++; $display("FAIL rst_reg%0d: got %h want 00", i, dbg_data); end
        end
`ifdef ALU_SEQ_CNT_EN
        nvec++; if (instr_cnt !== 16'd0) begin nerr++; $display("FAIL rst_cnt: got %0d want 0", instr_cnt); end
`endif
        $display("txn reset released");
    endtask

    // Load immediate: done in the cycle after the accept, value visible one cycle later.
    task automatic test_load(input logic [1:0] rd, input logic [7:0] imm, input logic exp_zf);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd0, rd, 2'd0, 2'd0, imm);
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL ld_ready: got %b want 1", bus.cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL ld_done: got %b want 1", done); end
        nvec++; if (bus.cmd_ready !== 1'b0) begin nerr++; $display("FAIL ld_busy: got %b want 0", bus.cmd_ready); end
        nvec++; if (bus.alu_en !== 1'b0) begin nerr++; $display("FAIL ld_alu_en: got %b want 0", bus.alu_en); end
        @(posedge clk);
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL ld_done_end: got %b want 0", done); end
        nvec++; if (zero_flag !== exp_zf) begin nerr++; $display("FAIL ld_zf: got %b want %b", zero_flag, exp_zf); end
        dbg_addr = rd;
        #1;
        nvec++; if (dbg_data !== imm) begin nerr++; $display("FAIL ld_r%0d: got %h want %h", rd, dbg_data, imm); end
        $display("txn load R%0d = %h", rd, imm);
    endtask

    // ALU instruction: ISSUE at N+1, done at N+2, result visible from N+3.
    task automatic test_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [7:0] exp_s1, input logic [7:0] exp_s2,
                            input logic [7:0] exp_res, input logic exp_zf);
        @(negedge clk);
        drive(1'b1, 1'b0, op, rd, rs1, rs2, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        nvec++; if (bus.alu_en !== 1'b1) begin nerr++; $display("FAIL issue_en: got %b want 1", bus.alu_en); end
        nvec++; if (bus.alu_op !== op) begin nerr++; $display("FAIL issue_op: got %b want %b", bus.alu_op, op); end
        nvec++; if (bus.alu_src1 !== exp_s1) begin nerr++; $display("FAIL issue_src1: got %h want %h", bus.alu_src1, exp_s1); end
        nvec++; if (bus.alu_src2 !== exp_s2) begin nerr++; $display("FAIL issue_src2: got %h want %h", bus.alu_src2, exp_s2); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL issue_done: got %b want 0", done); end
        nvec++; if (bus.cmd_ready !== 1'b0) begin nerr++; $display("FAIL issue_ready: got %b want 0", bus.cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL wb_done: got %b want 1", done); end
        nvec++; if (bus.alu_en !== 1'b0) begin nerr++; $display("FAIL wb_alu_en: got %b want 0", bus.alu_en); end
        @(posedge clk);
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL alu_done_end: got %b want 0", done); end
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL alu_ready: got %b want 1", bus.cmd_ready); end
        nvec++; if (zero_flag !== exp_zf) begin nerr++; $display("FAIL alu_zf: got %b want %b", zero_flag, exp_zf); end
        dbg_addr = rd;
        #1;
        nvec++; if (dbg_data !== exp_res) begin nerr++; $display("FAIL alu_r%0d: got %h want %h", rd, dbg_data, exp_res); end
        $display("txn op %b R%0d = f(R%0d, R%0d) = %h", op, rd, rs1, rs2, exp_res);
    endtask

    // cmd_valid is held high; the fields change only after each accept.
    // Starting from R0=00 R1=FF R2=08 R3=00:
    //   ADD R3=R2+R1=07, XOR R0=R1^R2=F7, AND R2=R0&R3=07, SUB R1=R3-R2=00
    task automatic test_back_to_back();
        logic [2:0] b_op  [4] = '{3'b000, 3'b110, 3'b100, 3'b001};
        logic [1:0] b_rd  [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
        logic [1:0] b_rs1 [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
        logic [1:0] b_rs2 [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [7:0] b_exp [4] = '{8'hF7, 8'h00, 8'h07, 8'h07};
        int acc [4];
        int last;
        int n;
        logic exp_en;
        logic exp_rdy;
        last = -10;
        n    = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            exp_en  = (j == last + 1);
            exp_rdy = (j >= last + 3);
            nvec++; if (bus.alu_en !== exp_en) begin nerr++; $display("FAIL b2b_en cyc%0d: got %b want %b", j, bus.alu_en, exp_en); end
            nvec++; if (bus.cmd_ready !== exp_rdy) begin nerr++; $display("FAIL b2b_ready cyc%0d: got %b want %b", j, bus.cmd_ready, exp_rdy); end
            if (n < 4) drive(1'b1, 1'b0, b_op[n], b_rd[n], b_rs1[n], b_rs2[n], 8'h00);
            else       drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
            if (bus.cmd_ready === 1'b1 && n < 4) begin
                acc[n] = j;
                last   = j;
                $display("txn b2b accept %0d op %b at cycle %0d", n, b_op[n], j);
                n++;
            end
        end
        nvec++; if (n !== 4) begin nerr++; $display("FAIL b2b_accepts: got %0d want 4", n); end
        for (int k = 0; k + 1 < n; k++) begin
            nvec++; if (acc[k+1] - acc[k] !== 3) begin nerr++; $display("FAIL b2b_spacing %0d: got %0d want 3", k, acc[k+1] - acc[k]); end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            nvec++; if (dbg_data !== b_exp[i]) begin nerr++; $display("FAIL b2b_r%0d: got %h want %h", i, dbg_data, b_exp[i]); end
        end
        nvec++; if (zero_flag !== 1'b1) begin nerr++; $display("FAIL b2b_zf: got %b want 1", zero_flag); end
`ifdef ALU_SEQ_CNT_EN
        nvec++; if (instr_cnt !== 16'd12) begin nerr++; $display("FAIL b2b_cnt: got %0d want 12", instr_cnt); end
`endif
    endtask

    // Reset during ISSUE of ADD R2=R0+R1: no write-back, no done, all state cleared.
    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        nvec++; if (bus.alu_en !== 1'b1) begin nerr++; $display("FAIL mid_issue: got %b want 1", bus.alu_en); end
        rst_n = 1'b0;
        #1;
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_done_async: got %b want 0", done); end
        nvec++; if (bus.alu_en !== 1'b0) begin nerr++; $display("FAIL mid_en_async: got %b want 0", bus.alu_en); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_done_rst cyc%0d: got %b want 0", j, done); end
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_done_post cyc%0d: got %b want 0", j, done); end
        end
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready: got %b want 1", bus.cmd_ready); end
        nvec++; if (zero_flag !== 1'b0) begin nerr++; $display("FAIL mid_zf: got %b want 0", zero_flag); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            nvec++; if (dbg_data !== 8'h00) begin nerr++; $display("FAIL mid_r%0d: got %h want 00", i, dbg_data); end
        end
`ifdef ALU_SEQ_CNT_EN
        nvec++; if (instr_cnt !== 16'd0) begin nerr++; $display("FAIL mid_cnt: got %0d want 0", instr_cnt); end
`endif
        $display("txn reset during issue");
    endtask

    initial begin
        test_reset();
        test_load(2'd0, 8'h05, 1'b0);
        test_load(2'd1, 8'h03, 1'b0);
        // ADD R2 = R0 + R1 = 05 + 03
        test_alu(3'b000, 2'd2, 2'd0, 2'd1, 8'h05, 8'h03, 8'h08, 1'b0);
        // SUB R3 = R0 - R0
        test_alu(3'b001, 2'd3, 2'd0, 2'd0, 8'h05, 8'h05, 8'h00, 1'b1);
        // A load of zero must not touch the sticky flag.
        test_load(2'd3, 8'h00, 1'b1);
        test_load(2'd0, 8'h80, 1'b1);
        // SHL R0 = R0 << 1 wraps to 00; src2 still carries R1 = 03
        test_alu(3'b010, 2'd0, 2'd0, 2'd1, 8'h80, 8'h03, 8'h00, 1'b1);
        // NOT R1 = ~R0; src2 carries R2 = 08
        test_alu(3'b111, 2'd1, 2'd0, 2'd2, 8'h00, 8'h08, 8'hFF, 1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
